// File: rtl/frame_burst_sequencer.sv
// frame_burst_sequencer
//   Walks one video frame as lines x (full bursts + optional tail burst), hands
//   each burst to the AXI burst master through a req/ack/fin handshake and emits
//   one step pulse per finished burst for the frame address generator.
// Ports
//   clock, rst_n        system clock, asynchronous active-low reset
//   frame_start         start pulse, accepted only while idle
//   line_bursts         full bursts per line           (captured at start)
//   tail_beats          tail beats per line, 0 = none   (captured at start)
//   frame_lines         lines per frame, 0 means 1      (captured at start)
//   burst_req/len       request and AXI len (beats-1), len valid with req
//   burst_ack/fin       master accept / burst finished
//   new_base            load base address pulse
//   burst_done          advance one full burst pulse
//   tail_done           jump to next line start pulse
//   busy, frame_done    frame in progress / end-of-frame pulse
module frame_burst_sequencer #(
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned BSIZE      = 16,
  parameter int unsigned TSIZE      = 8,
  parameter int unsigned LSIZE      = 16,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [BSIZE-1:0] line_bursts,
  input  logic [TSIZE-1:0] tail_beats,
  input  logic [LSIZE-1:0] frame_lines,
  output logic             burst_req,
  output logic [7:0]       burst_len,
  input  logic             burst_ack,
  input  logic             burst_fin,
  output logic             new_base,
  output logic             burst_done,
  output logic             tail_done,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_SETTLE,
    S_REQ,
    S_WAIT_FIN,
    S_STEP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [BSIZE-1:0] lb_q, lb_d;
  logic [TSIZE-1:0] tb_q, tb_d;
  logic [LSIZE-1:0] fl_q, fl_d;
  logic [BSIZE-1:0] b_cnt_q, b_cnt_d;
  logic [LSIZE-1:0] line_cnt_q, line_cnt_d;
  logic [SW-1:0]    settle_q, settle_d;

  logic             is_tail;
  logic             last_item;
  logic             work_left;
  logic [BSIZE:0]   b_next;
  logic [TSIZE-1:0] tail_m1;

  // b_cnt never exceeds lb: reaching lb means the current item is the tail.
  // The +1 compare is done one bit wider so a full-scale lb cannot wrap.
  assign is_tail   = (b_cnt_q == lb_q);
  assign b_next    = {1'b0, b_cnt_q} + {{BSIZE{1'b0}}, 1'b1};
  assign last_item = is_tail || ((tb_q == '0) && (b_next == {1'b0, lb_q}));
  assign work_left = ((lb_q != '0) || (tb_q != '0)) && (line_cnt_q < fl_q);
  assign tail_m1   = tb_q - TSIZE'(1);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lb_q       <= '0;
      tb_q       <= '0;
      fl_q       <= '0;
      b_cnt_q    <= '0;
      line_cnt_q <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      lb_q       <= lb_d;
      tb_q       <= tb_d;
      fl_q       <= fl_d;
      b_cnt_q    <= b_cnt_d;
      line_cnt_q <= line_cnt_d;
      settle_q   <= settle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lb_d       = lb_q;
    tb_d       = tb_q;
    fl_d       = fl_q;
    b_cnt_d    = b_cnt_q;
    line_cnt_d = line_cnt_q;
    settle_d   = settle_q;
    burst_req  = 1'b0;
    burst_len  = '0;
    new_base   = 1'b0;
    burst_done = 1'b0;
    tail_done  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          lb_d    = line_bursts;
          tb_d    = tail_beats;
          fl_d    = (frame_lines == '0) ? LSIZE'(1) : frame_lines;
          state_d = S_BASE;
        end
      end
      S_BASE: begin
        busy       = 1'b1;
        new_base   = 1'b1;
        line_cnt_d = '0;
        b_cnt_d    = '0;
        settle_d   = '0;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          settle_d = '0;
          state_d  = work_left ? S_REQ : S_DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_REQ: begin
        busy      = 1'b1;
        burst_req = 1'b1;
        burst_len = is_tail ? 8'(tail_m1) : 8'(BURST_LEN - 1);
        // A fin coinciding with the ack completes the burst straight away.
        if (burst_ack) state_d = burst_fin ? S_STEP : S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        busy = 1'b1;
        if (burst_fin) state_d = S_STEP;
      end
      S_STEP: begin
        busy     = 1'b1;
        settle_d = '0;
        if (last_item) begin
          tail_done  = 1'b1;
          b_cnt_d    = '0;
          line_cnt_d = line_cnt_q + LSIZE'(1);
        end else begin
          burst_done = 1'b1;
          b_cnt_d    = b_cnt_q + BSIZE'(1);
        end
        state_d = S_SETTLE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_burst_sequencer.sv
module tb_frame_burst_sequencer;

  localparam int BURST_LEN  = 64;
  localparam int BSIZE      = 16;
  localparam int TSIZE      = 8;
  localparam int LSIZE      = 16;
  localparam int SETTLE_CYC = 3;

  localparam int EV_NB = 0;
  localparam int EV_BD = 1;
  localparam int EV_TD = 2;
  localparam int EV_FD = 3;

  logic             clock;
  logic             rst_n;
  logic             frame_start;
  logic [BSIZE-1:0] line_bursts;
  logic [TSIZE-1:0] tail_beats;
  logic [LSIZE-1:0] frame_lines;
  logic             burst_req;
  logic [7:0]       burst_len;
  logic             burst_ack;
  logic             fin_rsp;
  logic             fin_force;
  logic             burst_fin;
  logic             new_base;
  logic             burst_done;
  logic             tail_done;
  logic             busy;
  logic             frame_done;

  assign burst_fin = fin_rsp | fin_force;

  frame_burst_sequencer #(
    .BURST_LEN (BURST_LEN),
    .BSIZE     (BSIZE),
    .TSIZE     (TSIZE),
    .LSIZE     (LSIZE),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .line_bursts(line_bursts),
    .tail_beats (tail_beats),
    .frame_lines(frame_lines),
    .burst_req  (burst_req),
    .burst_len  (burst_len),
    .burst_ack  (burst_ack),
    .burst_fin  (burst_fin),
    .new_base   (new_base),
    .burst_done (burst_done),
    .tail_done  (tail_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_vec = 0;
  int n_bad = 0;

  int exp_ev_q[$];
  int exp_len_q[$];

  int n_req = 0, n_bd = 0, n_td = 0, n_ev = 0, n_fd = 0;
  int cyc = 0, last_pulse = 0;
  logic       req_prev = 1'b0;
  logic [7:0] len_hold = '0;

  int ack_dly = 0, fin_dly = 0;
  int rsp_phase = 0, rsp_cnt = 0;
  logic rsp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected burst lengths and pulse order for one frame.
  function automatic void push_model(input int lb, input int tb, input int ln);
    int lines = (ln == 0) ? 1 : ln;
    exp_ev_q.push_back(EV_NB);
    if (lb != 0 || tb != 0) begin
      for (int l = 0; l < lines; l++) begin
        for (int b = 0; b < lb; b++) begin
          exp_len_q.push_back(BURST_LEN - 1);
          exp_ev_q.push_back((b == lb - 1 && tb == 0) ? EV_TD : EV_BD);
        end
        if (tb != 0) begin
          exp_len_q.push_back(tb - 1);
          exp_ev_q.push_back(EV_TD);
        end
      end
    end
    exp_ev_q.push_back(EV_FD);
  endfunction

  // AXI master stand-in: ack after ack_dly cycles of req, fin fin_dly cycles after ack.
  always begin
    @(posedge clock);
    #1;
    burst_ack = 1'b0;
    fin_rsp   = 1'b0;
    if (!rst_n || !rsp_en) begin
      rsp_phase = 0;
      rsp_cnt   = 0;
    end else if (rsp_phase == 0) begin
      if (burst_req) begin
        if (rsp_cnt >= ack_dly) begin
          burst_ack = 1'b1;
          rsp_cnt   = 0;
          if (fin_dly == 0) fin_rsp = 1'b1;
          else rsp_phase = 1;
        end else begin
          rsp_cnt++;
        end
      end
    end else begin
      if (rsp_cnt + 1 >= fin_dly) begin
        fin_rsp   = 1'b1;
        rsp_phase = 0;
        rsp_cnt   = 0;
      end else begin
        rsp_cnt++;
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    int npulse;
    int ev;
    cyc++;
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (burst_req) begin
        if (req_prev) chk("len_stable", int'(burst_len), int'(len_hold));
        else len_hold = burst_len;
      end
      req_prev = burst_req && !burst_ack;
      if (burst_req && burst_ack) begin
        n_req++;
        if (exp_len_q.size() == 0) chk("req_unexpected", int'(burst_len), -1);
        else chk("burst_len", int'(burst_len), exp_len_q.pop_front());
      end
      npulse = int'(new_base) + int'(burst_done) + int'(tail_done) + int'(frame_done);
      if (npulse != 0) begin
        chk("pulse_onehot", npulse, 1);
        ev = new_base ? EV_NB : burst_done ? EV_BD : tail_done ? EV_TD : EV_FD;
        n_ev++;
        if (ev == EV_BD) n_bd++;
        if (ev == EV_TD) n_td++;
        if (ev == EV_FD) begin
          n_fd++;
          chk("busy_at_done", int'(busy), 0);
        end
        if (ev != EV_NB) chk("pulse_gap_ok", int'(cyc - last_pulse > SETTLE_CYC), 1);
        last_pulse = cyc;
        if (exp_ev_q.size() == 0) chk("event_unexpected", ev, -1);
        else chk("event_order", ev, exp_ev_q.pop_front());
      end
    end
  end

  task automatic start_frame(input int lb, input int tb, input int ln);
    @(posedge clock);
    #1;
    line_bursts = BSIZE'(lb);
    tail_beats  = TSIZE'(tb);
    frame_lines = LSIZE'(ln);
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int start = n_fd;
    int k = 0;
    while (n_fd == start && k < 5000) begin
      @(posedge clock);
      k++;
    end
    if (n_fd == start) chk("frame_done_timeout", 0, 1);
    #1;
  endtask

  task automatic clear_counts();
    n_req = 0;
    n_bd  = 0;
    n_td  = 0;
  endtask

  task automatic check_frame(input string tag, input int reqs, input int bd, input int td);
    chk({tag, "_reqs"}, n_req, reqs);
    chk({tag, "_bd"}, n_bd, bd);
    chk({tag, "_td"}, n_td, td);
    chk({tag, "_evq_empty"}, exp_ev_q.size(), 0);
    chk({tag, "_lenq_empty"}, exp_len_q.size(), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  typedef struct {
    int lb;
    int tb;
    int ln;
    int ad;
    int fd;
    int reqs;
    int bd;
    int td;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ev_before;

    vecs[0] = '{lb: 2, tb: 16, ln: 2, ad: 0, fd: 0,  reqs: 6, bd: 4, td: 2};
    vecs[1] = '{lb: 3, tb: 0,  ln: 1, ad: 0, fd: 1,  reqs: 3, bd: 2, td: 1};
    vecs[2] = '{lb: 0, tb: 0,  ln: 3, ad: 0, fd: 0,  reqs: 0, bd: 0, td: 0};
    vecs[3] = '{lb: 2, tb: 8,  ln: 1, ad: 5, fd: 20, reqs: 3, bd: 2, td: 1};
    vecs[4] = '{lb: 0, tb: 5,  ln: 2, ad: 1, fd: 2,  reqs: 2, bd: 0, td: 2};
    vecs[5] = '{lb: 1, tb: 0,  ln: 0, ad: 0, fd: 0,  reqs: 1, bd: 0, td: 1};
    vecs[6] = '{lb: 0, tb: 1,  ln: 1, ad: 2, fd: 3,  reqs: 1, bd: 0, td: 1};

    rst_n       = 1'b1;
    frame_start = 1'b0;
    line_bursts = '0;
    tail_beats  = '0;
    frame_lines = '0;
    fin_force   = 1'b0;
    burst_ack   = 1'b0;
    fin_rsp     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req", int'(burst_req), 0);
    chk("rst_len", int'(burst_len), 0);
    chk("rst_pulses", int'({new_base, burst_done, tail_done, frame_done}), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clock);
    #3;
    rst_n  = 1'b1;
    rsp_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      clear_counts();
      ack_dly = vecs[i].ad;
      fin_dly = vecs[i].fd;
      push_model(vecs[i].lb, vecs[i].tb, vecs[i].ln);
      start_frame(vecs[i].lb, vecs[i].tb, vecs[i].ln);
      chk("busy_after_start", int'(busy), 1);
      wait_done();
      check_frame($sformatf("vec%0d", i), vecs[i].reqs, vecs[i].bd, vecs[i].td);
      repeat (2) @(posedge clock);
    end

    // frame_start and config changes while busy must be ignored
    clear_counts();
    ack_dly = 1;
    fin_dly = 4;
    push_model(1, 4, 2);
    start_frame(1, 4, 2);
    repeat (12) @(posedge clock);
    #1;
    chk("busy_mid_frame", int'(busy), 1);
    line_bursts = BSIZE'(3);
    tail_beats  = TSIZE'(0);
    frame_lines = LSIZE'(1);
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
    wait_done();
    check_frame("ignore_start", 4, 2, 2);
    clear_counts();
    ack_dly = 0;
    fin_dly = 1;
    push_model(3, 0, 1);
    start_frame(3, 0, 1);
    wait_done();
    check_frame("second_frame", 3, 2, 1);

    // reset while waiting for burst_fin, then a stray fin after release
    clear_counts();
    ack_dly = 0;
    fin_dly = 30;
    push_model(2, 0, 1);
    start_frame(2, 0, 1);
    for (int k = 0; k < 200 && n_req == 0; k++) @(posedge clock);
    chk("reset_seq_req_seen", n_req, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", int'(burst_req), 0);
    chk("midrst_len", int'(burst_len), 0);
    chk("midrst_pulses", int'({new_base, burst_done, tail_done, frame_done}), 0);
    chk("midrst_busy", int'(busy), 0);
    exp_ev_q.delete();
    exp_len_q.delete();
    repeat (2) @(posedge clock);
    #3;
    rst_n = 1'b1;
    ev_before = n_ev;
    @(posedge clock);
    #1;
    fin_force = 1'b1;
    @(posedge clock);
    #1;
    fin_force = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("stray_fin_no_event", n_ev, ev_before);
    chk("stray_fin_idle", int'(busy), 0);
    clear_counts();
    ack_dly = 2;
    fin_dly = 2;
    push_model(1, 3, 1);
    start_frame(1, 3, 1);
    wait_done();
    check_frame("after_reset", 2, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
